// File: rtl/vga_pkg.sv
// Shared VGA definitions: timing bundle from the timing generator, scanout
// state encoding and the nominal visible raster size.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;

  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic blank_n;
    logic end_of_line;
    logic end_of_frame;
  } VGA_Timing;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    RESYNC     = 2'd2
  } scanout_state_t;

  typedef enum logic [1:0] {
    RGB_ZERO  = 2'd0,
    RGB_FIFO  = 2'd1,
    RGB_UFLOW = 2'd2
  } rgb_sel_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data (updated on pop) and a
// synchronous flush that empties it in one cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = rdata_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rdata_d  = rdata_q;
    if (pop_ok) begin
      rdata_d  = mem_q[rd_ptr_q[AW-1:0]];
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/vga_pixel_scanout.sv
// Final VGA output stage: delays the timing bundle by one cycle, drains the
// prefetch FIFO onto visible pixels and recovers from underflow at frame edges.
//
// state      | meaning
// WAIT_FRAME | after reset; FIFO held empty, black output, waits for end_of_frame
// ACTIVE     | frame aligned; pops one word per visible pixel
// RESYNC     | underflow seen; magenta on visible pixels, upstream swallowed
module vga_pixel_scanout
  import vga_pkg::*;
#(
  parameter int                 PIXEL_W         = 16,
  parameter int                 FIFO_DEPTH      = 32,
  parameter logic [PIXEL_W-1:0] UNDERFLOW_COLOR = 16'hF81F,
  parameter int                 CNT_W           = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  VGA_Timing          timing_i,
  input  logic [PIXEL_W-1:0] pix_data_i,
  input  logic               pix_valid_i,
  output logic               pix_ready_o,
  output logic               frame_start_o,
  output logic               line_done_o,
  output logic [PIXEL_W-1:0] rgb_o,
  output logic               hsync_no,
  output logic               vsync_no,
  output logic               blank_no,
  output logic               underflow_o,
  input  logic               clear_i,
  output logic [CNT_W-1:0]   underflow_cnt_o
);

  scanout_state_t     state_q, state_d;
  rgb_sel_t           sel_q, sel_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               blank_q, blank_d;
  logic               fs_q, fs_d;
  logic               ld_q, ld_d;
  logic               uf_q, uf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_flush;
  logic               fifo_full;
  logic               fifo_empty;
  logic [PIXEL_W-1:0] fifo_rdata;
  logic               uf_evt;

  // RESYNC keeps ready high so a stalled upstream drains into the bit bucket.
  assign pix_ready_o = ((state_q == ACTIVE) && !fifo_full) || (state_q == RESYNC);
  assign fifo_push   = pix_valid_i && pix_ready_o && (state_q == ACTIVE);

  sync_fifo #(
    .WIDTH (PIXEL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (pix_data_i),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .rdata_o (fifo_rdata)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = RGB_ZERO;
    hsync_d    = timing_i.hsync_n;
    vsync_d    = timing_i.vsync_n;
    blank_d    = timing_i.blank_n;
    fs_d       = 1'b0;
    ld_d       = 1'b0;
    uf_d       = uf_q;
    cnt_d      = cnt_q;
    fifo_pop   = 1'b0;
    fifo_flush = (state_q != ACTIVE);
    uf_evt     = 1'b0;

    case (state_q)
      WAIT_FRAME: begin
        if (timing_i.end_of_frame) begin
          fs_d    = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        ld_d = timing_i.end_of_line;
        if (timing_i.blank_n) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sel_d    = RGB_FIFO;
          end else begin
            uf_evt     = 1'b1;
            sel_d      = RGB_UFLOW;
            fifo_flush = 1'b1;
            state_d    = RESYNC;
          end
        end
      end
      RESYNC: begin
        if (timing_i.blank_n) begin
          sel_d = RGB_UFLOW;
        end
        if (timing_i.end_of_frame) begin
          fs_d    = 1'b1;
          state_d = ACTIVE;
        end
      end
      default: begin
        state_d = WAIT_FRAME;
      end
    endcase

    if (clear_i) begin
      uf_d  = 1'b0;
      cnt_d = '0;
    end else if (uf_evt) begin
      uf_d  = 1'b1;
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WAIT_FRAME;
      sel_q   <= RGB_ZERO;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
      ld_q    <= 1'b0;
      uf_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
      ld_q    <= ld_d;
      uf_q    <= uf_d;
      cnt_q   <= cnt_d;
    end
  end

  // The FIFO read register is loaded on the same edge that selects it.
  always_comb begin
    rgb_o = '0;
    case (sel_q)
      RGB_FIFO:  rgb_o = fifo_rdata;
      RGB_UFLOW: rgb_o = UNDERFLOW_COLOR;
      default:   rgb_o = '0;
    endcase
  end

  assign hsync_no        = hsync_q;
  assign vsync_no        = vsync_q;
  assign blank_no        = blank_q;
  assign frame_start_o   = fs_q;
  assign line_done_o     = ld_q;
  assign underflow_o     = uf_q;
  assign underflow_cnt_o = cnt_q;

endmodule
